// File: rtl/mul8_rr_share.sv
// mul8_rr_share
//   Round-robin front end that time-shares one external combinational 8x8
//   multiplier among NREQ requesters. A granted operand pair is registered
//   onto mul_a/mul_b, the product on mul_o is captured one cycle later, and
//   it is returned with the owning requester ID over a valid/ready port.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester operand-pair valid
//   req_ready  : per-requester grant (combinational, at most one bit high)
//   req_a      : packed operand A, requester i at [8i+7:8i]
//   req_b      : packed operand B, same packing as req_a
//   mul_a      : registered operand A to the shared multiplier
//   mul_b      : registered operand B to the shared multiplier
//   mul_o      : combinational product returned by the multiplier
//   rsp_valid  : response holds a captured product
//   rsp_ready  : downstream accepts the response
//   rsp_data   : captured product
//   rsp_id     : requester index that owns rsp_data
module mul8_rr_share #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id
);

  localparam int unsigned OPW = 8;
  localparam int unsigned PW  = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_RSP  = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [OPW-1:0] mul_a_q, mul_a_d;
  logic [OPW-1:0] mul_b_q, mul_b_d;
  logic [PW-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic           rsp_valid_q, rsp_valid_d;

  logic           grant_ok_c;
  logic           gnt_found_c;
  logic [IDW-1:0] gnt_idx_c;
  logic [IDW-1:0] scan_idx_c;
  logic           hs_c;
  logic [OPW-1:0] sel_a_c;
  logic [OPW-1:0] sel_b_c;

  // A grant may only be issued when the multiplier path is free: either
  // nothing is in flight, or the held result is being consumed this cycle.
  always_comb begin
    grant_ok_c = (state_q == S_IDLE) || ((state_q == S_RSP) && rsp_ready);
  end

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    scan_idx_c  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      scan_idx_c = IDW'((32'(ptr_q) + k) % NREQ);
      if (!gnt_found_c && req_valid[scan_idx_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = scan_idx_c;
      end
    end
  end

  // Handshake happens exactly when a requester is selected and grant is allowed.
  always_comb begin
    hs_c = grant_ok_c && gnt_found_c;
  end

  // One-hot grant vector; all-zero when no grant is possible.
  always_comb begin
    req_ready = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = hs_c && (gnt_idx_c == IDW'(i));
    end
  end

  // Operand mux for the selected requester.
  always_comb begin
    sel_a_c = '0;
    sel_b_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_idx_c == IDW'(i)) begin
        sel_a_c = req_a[OPW*i +: OPW];
        sel_b_c = req_b[OPW*i +: OPW];
      end
    end
  end

  // Next-state and register-update logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    id_d       = id_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;

    // Operands only move on a handshake so the multiplier input is quiet
    // while a result is held.
    if (hs_c) begin
      mul_a_d = sel_a_c;
      mul_b_d = sel_b_c;
      id_d    = gnt_idx_c;
      ptr_d   = gnt_idx_c;
    end

    case (state_q)
      S_IDLE: begin
        if (hs_c) begin
          state_d = S_OP;
        end
      end
      S_OP: begin
        // Multiplier has had a full cycle to settle on the registered operands.
        rsp_data_d = mul_o;
        rsp_id_d   = id_q;
        state_d    = S_RSP;
      end
      S_RSP: begin
        if (rsp_ready) begin
          state_d = hs_c ? S_OP : S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    rsp_valid_d = (state_d == S_RSP);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      id_q        <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;

endmodule

// File: tb/tb_mul8_rr_share.sv
// tb_mul8_rr_share
//   Self-checking bench for mul8_rr_share with an exact multiplier stub on
//   mul_o and a transaction-level reference model sampled on the falling edge.
module tb_mul8_rr_share;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_a;
  logic [8*NREQ-1:0] req_b;
  logic [7:0]        mul_a;
  logic [7:0]        mul_b;
  logic [15:0]       mul_o;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_data;
  logic [IDW-1:0]    rsp_id;

  always #5 clk = ~clk;

  // Exact multiplier stub.
  assign mul_o = 16'(mul_a) * 16'(mul_b);

  mul8_rr_share #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_o     (mul_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: transaction view of the shared multiplier.
  int          m_ptr   = NREQ - 1;
  bit          m_op    = 1'b0;
  bit          m_hold  = 1'b0;
  int          m_op_id = 0;
  int          m_id    = 0;
  logic [7:0]  m_a     = '0;
  logic [7:0]  m_b     = '0;
  logic [15:0] m_prod  = '0;
  logic [15:0] m_data  = '0;
  int          last_g  = -1;
  int          cyc     = 0;

  int          gnt_log[$];
  int          rsp_cyc[$];
  logic [15:0] rsp_dat[$];
  int          rsp_idl[$];

  always @(negedge clk) begin : model
    int g;
    bit can;
    logic [NREQ-1:0] exp_rdy;
    int idx;
    g = -1;
    can = !m_op && (!m_hold || rsp_ready);
    if (can) begin
      for (int k = 1; k <= NREQ; k++) begin
        idx = (m_ptr + k) % NREQ;
        if (g < 0 && req_valid[idx[IDW-1:0]]) g = idx;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g[IDW-1:0]] = 1'b1;

    if (!rst) begin
      check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(m_hold));
      check_eq("mul_a", 32'(mul_a), 32'(m_a));
      check_eq("mul_b", 32'(mul_b), 32'(m_b));
      if (m_hold) begin
        check_eq("rsp_data", 32'(rsp_data), 32'(m_data));
        check_eq("rsp_id", 32'(rsp_id), 32'(m_id));
      end
    end

    if (rst) begin
      last_g = -1;
      m_ptr  = NREQ - 1;
      m_op   = 1'b0;
      m_hold = 1'b0;
      m_a    = '0;
      m_b    = '0;
    end else begin
      last_g = g;
      if (m_hold && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        rsp_dat.push_back(m_data);
        rsp_idl.push_back(m_id);
        m_hold = 1'b0;
      end
      if (m_op) begin
        m_data = m_prod;
        m_id   = m_op_id;
        m_hold = 1'b1;
        m_op   = 1'b0;
      end else if (g >= 0) begin
        m_a     = req_a[8*g +: 8];
        m_b     = req_b[8*g +: 8];
        m_prod  = 16'(m_a) * 16'(m_b);
        m_op    = 1'b1;
        m_op_id = g;
        m_ptr   = g;
        gnt_log.push_back(g);
      end
    end
    cyc++;
  end

  // Advance one cycle; a requester that was just granted drops its request.
  task automatic step();
    @(posedge clk);
    #1;
    if (last_g >= 0) req_valid[last_g[IDW-1:0]] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
    req_valid[i[IDW-1:0]] = v;
    req_a[8*i +: 8] = a;
    req_b[8*i +: 8] = b;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_cyc.delete();
    rsp_dat.delete();
    rsp_idl.delete();
  endtask

  function automatic logic [7:0] rand_op();
    int sel;
    sel = $urandom_range(0, 7);
    if (sel == 0) return 8'd0;
    if (sel == 1) return 8'd255;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    rst       = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values.
    check_eq("rst_mul_a", 32'(mul_a), 32'd0);
    check_eq("rst_mul_b", 32'(mul_b), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);

    // Single request.
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 8'd13, 8'd11);
    #1 check_eq("single_gnt", 32'(req_ready), 32'h1);
    step();
    check_eq("single_mul_a", 32'(mul_a), 32'd13);
    check_eq("single_mul_b", 32'(mul_b), 32'd11);
    step();
    check_eq("single_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("single_rsp_data", 32'(rsp_data), 32'd143);
    check_eq("single_rsp_id", 32'(rsp_id), 32'd0);
    step();
    step();

    // Round-robin with all requesters continuously valid.
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_logs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 8'(i + 1), 8'd10);
    repeat (9) begin
      step();
      for (int i = 0; i < NREQ; i++) req_valid[i] = 1'b1;
    end
    step();
    req_valid = '0;
    step();
    step();
    check_eq("rr_gnt_count", 32'(gnt_log.size()), 32'd5);
    check_eq("rr_rsp_count", 32'(rsp_dat.size()), 32'd5);
    if (gnt_log.size() == 5 && rsp_dat.size() == 5) begin
      for (int n = 0; n < 5; n++) begin
        check_eq("rr_gnt_order", 32'(gnt_log[n]), 32'(n % NREQ));
        check_eq("rr_rsp_data", 32'(rsp_dat[n]), 32'(((n % NREQ) + 1) * 10));
        check_eq("rr_rsp_id", 32'(rsp_idl[n]), 32'(n % NREQ));
        if (n > 0) check_eq("rr_rsp_spacing", 32'(rsp_cyc[n] - rsp_cyc[n-1]), 32'd2);
      end
    end

    // Backpressure with other requests pending.
    rsp_ready = 1'b0;
    set_req(2, 1'b1, 8'd255, 8'd255);
    step();
    set_req(0, 1'b1, 8'd5, 8'd6);
    set_req(1, 1'b1, 8'd7, 8'd8);
    step();
    repeat (5) begin
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_data", 32'(rsp_data), 32'd65025);
      check_eq("bp_rsp_id", 32'(rsp_id), 32'd2);
      check_eq("bp_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1 check_eq("bp_release_gnt", 32'(req_ready), 32'h1);
    repeat (6) step();

    // Pointer continuity across IDLE.
    set_req(2, 1'b1, 8'd3, 8'd4);
    repeat (3) step();
    clear_logs();
    set_req(0, 1'b1, 8'd9, 8'd9);
    set_req(3, 1'b1, 8'd12, 8'd12);
    repeat (6) step();
    check_eq("ptr_gnt_count", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() == 2) begin
      check_eq("ptr_first", 32'(gnt_log[0]), 32'd3);
      check_eq("ptr_second", 32'(gnt_log[1]), 32'd0);
    end

    // Reset during the OP cycle.
    set_req(2, 1'b1, 8'd77, 8'd3);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("mid_rst_mul_a", 32'(mul_a), 32'd0);
    check_eq("mid_rst_mul_b", 32'(mul_b), 32'd0);
    check_eq("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
    check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
    step();
    step();
    check_eq("mid_rst_no_rsp", 32'(rsp_valid), 32'd0);

    // Boundary operands back to back after reset.
    clear_logs();
    set_req(0, 1'b1, 8'd0, 8'd200);
    set_req(1, 1'b1, 8'd255, 8'd1);
    #1 check_eq("post_rst_gnt", 32'(req_ready), 32'h1);
    repeat (6) step();
    check_eq("bnd_rsp_count", 32'(rsp_dat.size()), 32'd2);
    if (rsp_dat.size() == 2 && gnt_log.size() == 2) begin
      check_eq("bnd_gnt0", 32'(gnt_log[0]), 32'd0);
      check_eq("bnd_gnt1", 32'(gnt_log[1]), 32'd1);
      check_eq("bnd_zero_data", 32'(rsp_dat[0]), 32'd0);
      check_eq("bnd_zero_id", 32'(rsp_idl[0]), 32'd0);
      check_eq("bnd_max_data", 32'(rsp_dat[1]), 32'd255);
      check_eq("bnd_max_id", 32'(rsp_idl[1]), 32'd1);
      check_eq("bnd_spacing", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd2);
    end

    // Randomized traffic with random backpressure.
    clear_logs();
    repeat (1500) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, 1'b1, rand_op(), rand_op());
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (6) step();
    check_eq("rand_balanced", 32'(rsp_dat.size()), 32'(gnt_log.size()));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
